// File: rtl/spi_master_port_if.sv
// Request and SPI pin bundle for spi_master_port.
// master: the SPI initiator itself. slave: the test logic that issues requests and models the link.
interface spi_master_port_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       miso_pin;

  modport master (
    input  start, rw, addr, wdata, miso_pin,
    output busy, done, rdata, sclk_pin, cs_pin, mosi_pin
  );

  modport slave (
    output start, rw, addr, wdata, miso_pin,
    input  busy, done, rdata, sclk_pin, cs_pin, mosi_pin
  );
endinterface

// File: rtl/spi_master_port.sv
// spi_master_port: mode-0 SPI initiator issuing one 16-bit {addr,rw,data} frame per request.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | pins idle, waiting for start
// S_SETUP    | cs low, first MOSI bit driven, half period before rise 1
// S_SHIFT    | 16 SCLK periods: sample MISO on rise, next MOSI bit on fall
// S_HOLD     | half period after the last fall, then cs released
// S_WAIT_GAP | cs high for GAP cycles, then done pulse
module spi_master_port #(
  parameter int HALF = 8,
  parameter int GAP  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_port_if.master bus
);
  localparam int DIV_W = $clog2(HALF + 1);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_WAIT_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [GAP_W-1:0] r_gap;
  logic [4:0]       r_bit_cnt;
  logic [15:0]      r_tx;
  logic [7:0]       r_rx;
  logic             r_rw;
  logic             r_miso_meta;
  logic             r_miso_sync;
  logic             r_sclk;
  logic             r_cs;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_rdata;

  logic w_div_tc;
  logic w_gap_tc;
  logic w_last_bit;
  logic w_accept;
  logic w_rise;
  logic w_fall;
  logic w_cs_release;
  logic w_finish;

  assign w_div_tc   = (r_div == '0);
  assign w_gap_tc   = (r_gap == '0);
  assign w_last_bit = (r_bit_cnt == 5'd15);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (bus.start)                          w_state_nxt = S_SETUP;
      S_SETUP:    if (w_div_tc)                           w_state_nxt = S_SHIFT;
      S_SHIFT:    if (w_div_tc && r_sclk && w_last_bit)   w_state_nxt = S_HOLD;
      S_HOLD:     if (w_div_tc)                           w_state_nxt = S_WAIT_GAP;
      S_WAIT_GAP: if (w_gap_tc)                           w_state_nxt = S_IDLE;
      default:                                            w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state action strobes for the datapath.
  always_comb begin
    w_accept     = 1'b0;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_cs_release = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE:     w_accept = bus.start;
      S_SETUP:    w_rise   = w_div_tc;
      S_SHIFT: begin
        w_rise = w_div_tc & ~r_sclk;
        w_fall = w_div_tc &  r_sclk;
      end
      S_HOLD:     w_cs_release = w_div_tc;
      S_WAIT_GAP: w_finish     = w_gap_tc;
      default: ;
    endcase
  end

  // Half-period and gap down-counters; each reloads on its event and parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_gap <= '0;
    end else begin
      if (w_accept || w_rise || w_fall) r_div <= DIV_LOAD;
      else if (!w_div_tc)               r_div <= r_div - 1'b1;
      if (w_cs_release)                 r_gap <= GAP_LOAD;
      else if (!w_gap_tc)               r_gap <= r_gap - 1'b1;
    end
  end

  // Frame shift registers; r_tx[15] is the MOSI pin and shifts in zeros, so it idles low after bit 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_rw      <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_tx      <= {bus.addr, bus.rw, (bus.rw ? 8'h00 : bus.wdata)};
        r_rw      <= bus.rw;
        r_bit_cnt <= '0;
      end else if (w_fall) begin
        r_tx      <= {r_tx[14:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_rise) r_rx <= {r_rx[6:0], r_miso_sync};
    end
  end

  // MISO two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_miso_meta <= bus.miso_pin;
      r_miso_sync <= r_miso_meta;
    end
  end

  // Registered pins and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done <= w_finish;
      if (w_rise)                r_sclk  <= 1'b1;
      else if (w_fall)           r_sclk  <= 1'b0;
      if (w_accept)              r_cs    <= 1'b0;
      else if (w_cs_release)     r_cs    <= 1'b1;
      if (w_accept)              r_busy  <= 1'b1;
      else if (w_finish)         r_busy  <= 1'b0;
      if (w_finish && r_rw)      r_rdata <= r_rx;
    end
  end

  assign bus.sclk_pin = r_sclk;
  assign bus.cs_pin   = r_cs;
  assign bus.mosi_pin = r_tx[15];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rdata    = r_rdata;
endmodule

// File: tb/tb_spi_master_port.sv
// Bench for spi_master_port: behavioural memory slave plus a frame/timing reference model.
module tb_spi_master_port;
  localparam int HALF   = 8;
  localparam int GAP    = 16;
  localparam int T_DONE = 33 * HALF + GAP;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_master_port_if if0 ();
  spi_master_port_if if1 ();

  spi_master_port #(.HALF(HALF), .GAP(GAP)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  spi_master_port #(.HALF(12),   .GAP(4))   u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: memory contents and the rdata the port should hold.
  logic [7:0] ref_mem [0:127];
  logic [7:0] exp_rdata = 8'h00;

  // Behavioural spiMemory: samples MOSI on rise, drives read byte on falls 8..15, commits on cs rise.
  logic [7:0]  s_mem [0:127];
  logic [15:0] s_sr = '0;
  logic [7:0]  s_out = '0;
  logic        s_miso = 1'b0;
  logic        s_cs_q = 1'b1;
  logic        s_sclk_q = 1'b0;
  int          s_nr = 0;
  int          s_nf = 0;
  logic [15:0] frames [$];

  assign if0.miso_pin = s_miso;
  assign if1.miso_pin = 1'b1;

  always @(if0.sclk_pin or if0.cs_pin) begin
    if (if0.cs_pin === 1'b0 && s_cs_q !== 1'b0) begin
      s_nr = 0;
      s_nf = 0;
    end else if (if0.cs_pin === 1'b0 && if0.sclk_pin === 1'b1 && s_sclk_q === 1'b0) begin
      s_sr = {s_sr[14:0], if0.mosi_pin};
      s_nr++;
    end else if (if0.cs_pin === 1'b0 && if0.sclk_pin === 1'b0 && s_sclk_q === 1'b1) begin
      s_nf++;
      if (s_nf == 8) s_out = s_sr[0] ? s_mem[s_sr[7:1]] : 8'h00;
      if (s_nf >= 8 && s_nf < 16) s_miso = s_out[3'(15 - s_nf)];
    end
    if (if0.cs_pin === 1'b1 && s_cs_q === 1'b0 && s_nr == 16) begin
      frames.push_back(s_sr);
      if (!s_sr[8]) s_mem[s_sr[15:9]] = s_sr[7:0];
    end
    s_cs_q   = if0.cs_pin;
    s_sclk_q = if0.sclk_pin;
  end

  // Pin monitors for the default-parameter port.
  int   n_done0 = 0;
  int   cs_low = 0;
  int   mosi_bad = 0;
  int   hi_run = 0;
  int   hi_runs [$];
  logic m_mosi_q = 1'b0;
  logic m_sclk_q = 1'b0;
  logic m_cs_q = 1'b1;

  always @(negedge clk) begin
    if (if0.done === 1'b1) n_done0++;
    if (if0.cs_pin === 1'b0) cs_low++;
    if (if0.cs_pin === 1'b1) hi_run++;
    else if (hi_run > 0) begin
      hi_runs.push_back(hi_run);
      hi_run = 0;
    end
    if (rst_n === 1'b1 && if0.mosi_pin !== m_mosi_q &&
        !(m_sclk_q === 1'b1 && if0.sclk_pin === 1'b0) &&
        !(m_cs_q === 1'b1 && if0.cs_pin === 1'b0))
      mosi_bad++;
    m_mosi_q = if0.mosi_pin;
    m_sclk_q = if0.sclk_pin;
    m_cs_q   = if0.cs_pin;
  end

  // SCLK phase monitor for the HALF=12 port: every phase inside a frame must last 12 cycles.
  int   run1 = 0;
  int   bad1 = 0;
  int   rises1 = 0;
  logic p1_sclk = 1'b0;

  always @(negedge clk) begin
    if (if1.cs_pin !== 1'b0) begin
      run1    = 0;
      p1_sclk = 1'b0;
    end else if (if1.sclk_pin === p1_sclk) begin
      run1++;
    end else begin
      if (run1 != 12) bad1++;
      run1    = 1;
      p1_sclk = if1.sclk_pin;
      if (if1.sclk_pin === 1'b1) rises1++;
    end
  end

  task automatic wait_done0(output bit seen);
    int t = 0;
    while (if0.done !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    seen = (if0.done === 1'b1);
    if (!seen) check_eq("done_seen", if0.done, 1);
  endtask

  task automatic run_xact(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int  e0;
    int  nfr;
    bit  seen;
    @(negedge clk);
    if0.start = 1'b1;
    if0.rw    = rw;
    if0.addr  = a;
    if0.wdata = d;
    cs_low    = 0;
    nfr       = frames.size();
    @(negedge clk);
    e0 = cyc;
    if0.start = 1'b0;
    if0.rw    = 1'($urandom);
    if0.addr  = 7'($urandom);
    if0.wdata = 8'($urandom);
    check_eq("busy_after_start", if0.busy, 1);
    wait_done0(seen);
    if (seen) begin
      check_eq("done_latency", cyc - e0, T_DONE);
      check_eq("busy_at_done", if0.busy, 0);
      check_eq("cs_low_cycles", cs_low, 33 * HALF);
      if (rw) exp_rdata = ref_mem[a];
      else    ref_mem[a] = d;
      check_eq("rdata", if0.rdata, exp_rdata);
      check_eq("frame_count", frames.size(), nfr + 1);
      if (frames.size() > 0)
        check_eq("frame", frames.pop_front(), {a, rw, (rw ? 8'h00 : d)});
      @(negedge clk);
      check_eq("done_width", if0.done, 0);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic [7:0]  d;
    logic [6:0]  a;
    logic [15:0] exp_q [$];
    int          t_done [3];
    int          nd;
    int          nfr;
    int          e0;
    int          t;
    bit          seen;
    logic        rw;

    rst_n = 1'b0;
    if0.start = 1'b0; if0.rw = 1'b0; if0.addr = '0; if0.wdata = '0;
    if1.start = 1'b0; if1.rw = 1'b0; if1.addr = '0; if1.wdata = '0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'h00;
      s_mem[i]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_eq("reset_pins", {if0.cs_pin, if0.sclk_pin, if0.mosi_pin, if0.busy, if0.done, if0.rdata},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write then read-back.
    run_xact(1'b0, 7'h2A, 8'hA5);
    run_xact(1'b1, 7'h2A, 8'h3C);

    // Random mix over a small address window so reads hit earlier writes.
    for (int i = 0; i < 6; i++) begin
      run_xact(1'($urandom), 7'($urandom_range(0, 15)), 8'($urandom));
    end

    // Second start mid-frame must be ignored.
    nd  = n_done0;
    nfr = frames.size();
    d   = 8'($urandom);
    @(negedge clk);
    if0.start = 1'b1; if0.rw = 1'b0; if0.addr = 7'h10; if0.wdata = d;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (100) @(negedge clk);
    if0.start = 1'b1; if0.addr = 7'h7F; if0.wdata = ~d;
    repeat (20) @(negedge clk);
    if0.start = 1'b0;
    repeat (400) @(negedge clk);
    ref_mem[7'h10] = d;
    check_eq("ignore_done_count", n_done0, nd + 1);
    check_eq("ignore_frame_count", frames.size(), nfr + 1);
    if (frames.size() > 0) check_eq("ignore_frame", frames.pop_front(), {7'h10, 1'b0, d});

    // Back-to-back writes with start held high.
    hi_runs.delete();
    exp_q.delete();
    @(negedge clk);
    a = 7'($urandom_range(0, 15)); d = 8'($urandom);
    if0.start = 1'b1; if0.rw = 1'b0; if0.addr = a; if0.wdata = d;
    exp_q.push_back({a, 1'b0, d});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_done0(seen);
      t_done[k] = cyc;
      ref_mem[a] = d;
      if (k < 2) begin
        a = 7'($urandom_range(0, 15)); d = 8'($urandom);
        if0.addr = a; if0.wdata = d;
        exp_q.push_back({a, 1'b0, d});
      end else begin
        if0.start = 1'b0;
      end
    end
    check_eq("b2b_spacing_1", t_done[1] - t_done[0], T_DONE + 1);
    check_eq("b2b_spacing_2", t_done[2] - t_done[1], T_DONE + 1);
    check_eq("b2b_cs_high_runs", hi_runs.size(), 3);
    if (hi_runs.size() == 3) begin
      check_eq("b2b_cs_gap_1", hi_runs[1], GAP + 1);
      check_eq("b2b_cs_gap_2", hi_runs[2], GAP + 1);
    end
    for (int k = 0; k < 3; k++) begin
      if (frames.size() > 0) check_eq("b2b_frame", frames.pop_front(), exp_q[k]);
      else check_eq("b2b_frame_count", frames.size(), 3 - k);
    end

    // Make rdata non-zero, then reset in the middle of a write.
    run_xact(1'b1, 7'h2A, 8'h00);
    nd  = n_done0;
    nfr = frames.size();
    @(negedge clk);
    if0.start = 1'b1; if0.rw = 1'b0; if0.addr = 7'h2A; if0.wdata = 8'h5A;
    @(negedge clk);
    if0.start = 1'b0;
    t = 0;
    while (s_nr < 5 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq("reset_reached_rise5", s_nr, 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset_pins", {if0.cs_pin, if0.sclk_pin, if0.busy, if0.done}, {1'b1, 1'b0, 1'b0, 1'b0});
    check_eq("midreset_rdata", if0.rdata, 8'h00);
    exp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("midreset_no_done", n_done0, nd);
    check_eq("midreset_no_frame", frames.size(), nfr);
    run_xact(1'b1, 7'h2A, 8'h00);

    // Timing at HALF=12, GAP=4 on the second port.
    rw = 1'($urandom);
    rises1 = 0;
    bad1   = 0;
    @(negedge clk);
    if1.start = 1'b1; if1.rw = rw; if1.addr = 7'($urandom); if1.wdata = 8'($urandom);
    @(negedge clk);
    e0 = cyc;
    if1.start = 1'b0;
    t = 0;
    while (if1.done !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("t12_done_latency", cyc - e0, 33 * 12 + 4);
    check_eq("t12_rise_count", rises1, 16);
    check_eq("t12_bad_phases", bad1, 0);
    check_eq("t12_rdata", if1.rdata, rw ? 32'hFF : 32'h00);

    check_eq("mosi_change_rule", mosi_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_master_port.md
Name: spi_master_port

Overview:
- SPI initiator that drives the team's SPI memory slave (`spiMemory`) from a simple parallel request interface.
- Issues one 16-bit transaction per request:
  - Byte 0 is {addr[6:0], rw}, with rw in bit 0 (1 = read, 0 = write).
  - Byte 1 is the write data, or a dummy byte during reads.
- Used by on-FPGA test logic and bring-up benches to write and read back the slave's 128-byte data memory.
- Mode 0 link: SCLK idles low, MSB first.

Parameters:
HALF, 8, clk cycles per SCLK half-period; must be >= 8 to cover the slave's input-conditioner latency.
GAP, 16, clk cycles cs_pin is held high after a transaction before done asserts.

Ports:
clk  input  1  FPGA clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only in IDLE
rw  input  1  1 = read, 0 = write; latched at start
addr  input  7  target address; latched at start
wdata  input  8  write data; latched at start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at transaction end
rdata  output  8  read result; updated only at done of a read, held otherwise
sclk_pin  output  1  SPI clock
cs_pin  output  1  SPI chip select, active low
mosi_pin  output  1  master out slave in
miso_pin  input  1  master in slave out; passed through a 2-flop synchronizer before use

Behaviour:
- Reset, asynchronous while rst_n=0:
  - sclk_pin=0, cs_pin=1, mosi_pin=0, busy=0, done=0, rdata=0x00.
  - State returns to IDLE and all counters clear.
- Internal registers: 16-bit tx shift register, 8-bit rx shift register, divider counter (0..HALF-1), bit counter (0..16), GAP counter.
- FSM states:
  - IDLE:
    - Accepts start=1 at clock edge E0.
    - Latches tx = {addr, rw, wdata} (rw=1 forces the data byte to 0x00).
    - Sets cs_pin=0, busy=1 and mosi_pin=tx[15], then moves to SETUP.
  - SETUP: waits HALF cycles, then raises sclk_pin at E0+HALF and moves to SHIFT.
  - SHIFT:
    - The divider toggles sclk_pin every HALF cycles.
    - Rising edge k (k=1..16) occurs at E0+HALF*(2k-1); falling edge k at E0+2k*HALF.
    - On each rising edge, the synchronized MISO value shifts into rdata_sr LSB; only edges 9..16 are meaningful.
    - On each falling edge k<16, tx shifts left and mosi_pin takes the next bit.
    - On falling edge 16, mosi_pin=0 and the FSM moves to HOLD.
  - HOLD: waits HALF cycles, sets cs_pin=1 at E0+33*HALF, then moves to WAIT_GAP.
  - WAIT_GAP:
    - Counts GAP cycles.
    - At edge E0+33*HALF+GAP: done=1 for one cycle and busy=0.
    - If rw=1, rdata=rdata_sr at that same edge.
    - Returns to IDLE.
- Default timing: HALF=8, GAP=16, so done asserts 280 cycles after E0.
- Handshake rules:
  - start while busy=1 is ignored entirely; no queuing.
  - start held high continuously yields back-to-back transactions; the next one begins at the edge after done, and cs_pin stays high for at least GAP+1 cycles between them.
  - Request inputs may change freely after acceptance.
- Data and timing rules:
  - MOSI changes only on clk edges where sclk_pin falls, or at cs_pin assertion.
  - MOSI is stable for >= HALF cycles around every rising edge.
  - Read data is MSB first: bit 7 is sampled at rising edge 9, bit 0 at rising edge 16.
  - Write transactions never modify rdata.
- Reset mid-transaction:
  - Pins return to idle immediately: cs_pin=1, sclk_pin=0.
  - done does not pulse and rdata returns to 0x00.
- Glitch freedom: sclk_pin and cs_pin are driven directly from flops, so there are no combinational glitches.

Test Plan:
- Write: rw=0, addr=0x2A, wdata=0xA5 -> MOSI bits on rising edges are 0x54 then 0xA5; cs_pin low for exactly 33*HALF=264 cycles; done at E0+280; rdata stays 0x00.
- Read-back: with spiMemory connected, run the write above, then issue rw=1, addr=0x2A -> byte 0 on MOSI is 0x55, byte 1 is 0x00; rdata=0xA5 at done.
- Timing: HALF=12, GAP=4, random request -> SCLK high/low phases exactly 12 cycles; exactly 16 rising edges per transaction; done at E0+33*12+4=400.
- Ignore-while-busy: pulse start with addr=0x10 and again mid-transaction with addr=0x7F -> exactly one transaction, to address 0x10; one done pulse.
- Back-to-back: start held high over 3 transactions -> 3 done pulses 281 cycles apart at defaults; cs_pin high >= 17 cycles between frames.
- Reset mid-frame: assert rst_n=0 after rising edge 5 -> cs_pin=1, sclk_pin=0, busy=0 in the same cycle; no done; the next transaction after release completes correctly.
